// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state, forwarding-select types and constants for pipeline control
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LOAD_USE = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_ALU = 2'd1,
    FWD_LD  = 2'd2
  } fwd_sel_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic fwd_sel_t fwd_pick(input logic hit, input fwd_sel_t src);
    return hit ? src : FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational MEM-WB destination vs DE-EX source register compare
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       rf_wr_mem,
  input  logic [4:0] rd_mem,
  input  logic [4:0] rs1_de,
  input  logic [4:0] rs2_de,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       hazard1,
  output logic       hazard2
);

  logic rd_live;

  // x0 is hardwired to zero, so a write to it never produces a dependency
  assign rd_live = rf_wr_mem && (rd_mem != 5'd0);
  assign hazard1 = rd_live && rs1_used && (rs1_de == rd_mem);
  assign hazard2 = rd_live && rs2_used && (rs2_de == rd_mem);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward sequencing for IF | DE-EX | MEM-WB; HAZARD_PERF_EN adds perf counters
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic        trap,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        mem_is_load,
  input  logic        rf_wr_mem,
  input  logic [4:0]  rd_mem,
  input  logic [4:0]  rs1_de,
  input  logic [4:0]  rs2_de,
  input  logic        rs1_used,
  input  logic        rs2_used,
  output logic        stall_if,
  output logic        stall_de,
  output logic        stall_mem,
  output logic        flush_de,
  output logic        flush_mem,
  output logic        ld_capture,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic        mem_fault,
  output logic        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [15:0] perf_fault_cnt
`endif
);

  localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       state, state_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              lu1, lu2, lu1_nxt, lu2_nxt;
  logic              hazard1, hazard2, ld_hazard;

  hazard_detect u_detect (
    .rf_wr_mem (rf_wr_mem),
    .rd_mem    (rd_mem),
    .rs1_de    (rs1_de),
    .rs2_de    (rs2_de),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .hazard1   (hazard1),
    .hazard2   (hazard2)
  );

  assign ld_hazard = mem_is_load && (hazard1 || hazard2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      tcnt  <= '0;
      lu1   <= 1'b0;
      lu2   <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      lu1   <= lu1_nxt;
      lu2   <= lu2_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tcnt_nxt   = tcnt;
    lu1_nxt    = lu1;
    lu2_nxt    = lu2;
    stall_if   = 1'b0;
    stall_de   = 1'b0;
    stall_mem  = 1'b0;
    flush_de   = 1'b0;
    flush_mem  = 1'b0;
    ld_capture = 1'b0;
    fwd_sel1   = FWD_RF;
    fwd_sel2   = FWD_RF;
    mem_fault  = 1'b0;
    busy       = (state != RUN);

    case (state)
      RUN: begin
        tcnt_nxt = '0;
        if (trap) begin
          flush_de  = 1'b1;
          flush_mem = 1'b1;
        end else if (dmem_req && !dmem_ack) begin
          stall_if  = 1'b1;
          stall_de  = 1'b1;
          stall_mem = 1'b1;
          state_nxt = MEM_WAIT;
          tcnt_nxt  = TCNT_W'(1);
        end else if (dmem_req && ld_hazard) begin
          ld_capture = 1'b1;
          stall_if   = 1'b1;
          stall_de   = 1'b1;
          flush_mem  = 1'b1;
          state_nxt  = LOAD_USE;
          lu1_nxt    = hazard1;
          lu2_nxt    = hazard2;
        end else begin
          // forwarding stays independent of br_taken so branch resolution cannot loop through it
          flush_de   = br_taken;
          fwd_sel1   = fwd_pick(hazard1 && !mem_is_load, FWD_ALU);
          fwd_sel2   = fwd_pick(hazard2 && !mem_is_load, FWD_ALU);
          ld_capture = dmem_ack && mem_is_load;
        end
      end

      MEM_WAIT: begin
        stall_if  = 1'b1;
        stall_de  = 1'b1;
        stall_mem = 1'b1;
        tcnt_nxt  = tcnt + TCNT_W'(1);
        if (trap) begin
          stall_if  = 1'b0;
          stall_de  = 1'b0;
          stall_mem = 1'b0;
          flush_de  = 1'b1;
          flush_mem = 1'b1;
          state_nxt = RUN;
          tcnt_nxt  = '0;
        end else if (dmem_ack) begin
          tcnt_nxt   = '0;
          ld_capture = mem_is_load;
          stall_mem  = 1'b0;
          if (ld_hazard) begin
            flush_mem = 1'b1;
            state_nxt = LOAD_USE;
            lu1_nxt   = hazard1;
            lu2_nxt   = hazard2;
          end else begin
            stall_if  = 1'b0;
            stall_de  = 1'b0;
            state_nxt = RUN;
          end
        end else if (tcnt == TCNT_W'(MEM_TIMEOUT)) begin
          mem_fault = 1'b1;
          flush_mem = 1'b1;
          state_nxt = RUN;
          tcnt_nxt  = '0;
        end
      end

      LOAD_USE: begin
        fwd_sel1  = fwd_pick(lu1, FWD_LD);
        fwd_sel2  = fwd_pick(lu2, FWD_LD);
        flush_de  = br_taken || trap;
        flush_mem = trap;
        state_nxt = RUN;
        lu1_nxt   = 1'b0;
        lu2_nxt   = 1'b0;
      end

      default: begin
        state_nxt = RUN;
        tcnt_nxt  = '0;
      end
    endcase

    // outputs must clear the moment reset asserts, even while inputs still request a stall
    if (!rst_n) begin
      stall_if   = 1'b0;
      stall_de   = 1'b0;
      stall_mem  = 1'b0;
      flush_de   = 1'b0;
      flush_mem  = 1'b0;
      ld_capture = 1'b0;
      fwd_sel1   = FWD_RF;
      fwd_sel2   = FWD_RF;
      mem_fault  = 1'b0;
      busy       = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_fault_cnt <= '0;
    end else begin
      if (stall_if && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_de && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (mem_fault && (perf_fault_cnt != '1)) perf_fault_cnt <= perf_fault_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed bench for hazard_controller against a cycle-count model
module tb_hazard_controller;

  localparam int TMO = 4;

  logic       clk, rst_n;
  logic       br_taken, trap, dmem_req, dmem_ack, mem_is_load, rf_wr_mem;
  logic [4:0] rd_mem, rs1_de, rs2_de;
  logic       rs1_used, rs2_used;
  logic       stall_if, stall_de, stall_mem, flush_de, flush_mem, ld_capture;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic       mem_fault, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
  logic [15:0] perf_fault_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: cycles spent waiting on memory (0 = none) and a pending load-use bubble
  int mw_cnt;
  bit lu_pend, lu_h1, lu_h2;

  hazard_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .trap(trap),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .mem_is_load(mem_is_load),
    .rf_wr_mem(rf_wr_mem), .rd_mem(rd_mem), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .stall_if(stall_if), .stall_de(stall_de), .stall_mem(stall_mem),
    .flush_de(flush_de), .flush_mem(flush_mem), .ld_capture(ld_capture),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mem_fault(mem_fault), .busy(busy)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
    .perf_fault_cnt(perf_fault_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(bit sif, bit sde, bit smem, bit fde, bit fmem, bit ldc,
                                       logic [1:0] f1, logic [1:0] f2, bit mf, bit bsy);
    return {sif, sde, smem, fde, fmem, ldc, f1, f2, mf, bsy};
  endfunction

  function automatic logic [11:0] observed();
    return {stall_if, stall_de, stall_mem, flush_de, flush_mem, ld_capture,
            fwd_sel1, fwd_sel2, mem_fault, busy};
  endfunction

  function automatic bit dep(logic [4:0] rs, logic used);
    return rf_wr_mem && (rd_mem != 0) && used && (rs == rd_mem);
  endfunction

  function automatic logic [11:0] model_expect();
    bit h1 = dep(rs1_de, rs1_used);
    bit h2 = dep(rs2_de, rs2_used);
    bit lu = mem_is_load && (h1 || h2);
    if (!rst_n) return '0;
    if (lu_pend)
      return pack(0, 0, 0, br_taken || trap, trap, 0,
                  lu_h1 ? 2'd2 : 2'd0, lu_h2 ? 2'd2 : 2'd0, 0, 1);
    if (mw_cnt > 0) begin
      if (trap) return pack(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
      if (dmem_ack) return lu ? pack(1, 1, 0, 0, 1, 1, 0, 0, 0, 1)
                              : pack(0, 0, 0, 0, 0, mem_is_load, 0, 0, 0, 1);
      if (mw_cnt == TMO) return pack(1, 1, 1, 0, 1, 0, 0, 0, 1, 1);
      return pack(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    end
    if (trap) return pack(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    if (dmem_req && !dmem_ack) return pack(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    if (dmem_req && lu) return pack(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    return pack(0, 0, 0, br_taken, 0, dmem_ack && mem_is_load,
                (h1 && !mem_is_load) ? 2'd1 : 2'd0, (h2 && !mem_is_load) ? 2'd1 : 2'd0, 0, 0);
  endfunction

  task automatic model_advance();
    bit h1 = dep(rs1_de, rs1_used);
    bit h2 = dep(rs2_de, rs2_used);
    bit lu = mem_is_load && (h1 || h2);
    bit was_waiting = (mw_cnt > 0);
    if (lu_pend) begin
      lu_pend = 0;
    end else if (was_waiting) begin
      if (trap) mw_cnt = 0;
      else if (dmem_ack) begin
        mw_cnt = 0;
        if (lu) begin lu_pend = 1; lu_h1 = h1; lu_h2 = h2; end
      end else if (mw_cnt == TMO) mw_cnt = 0;
      else mw_cnt++;
    end else if (!trap) begin
      if (dmem_req && !dmem_ack) mw_cnt = 1;
      else if (dmem_req && lu) begin lu_pend = 1; lu_h1 = h1; lu_h2 = h2; end
    end
  endtask

  task automatic idle();
    br_taken = 0; trap = 0; dmem_req = 0; dmem_ack = 0; mem_is_load = 0; rf_wr_mem = 0;
    rd_mem = 0; rs1_de = 0; rs2_de = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    idle();
    rst_n = 0;
    dmem_req = 1;
    repeat (2) @(negedge clk);
    #1;
    e = '0;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL reset_outputs got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    #1;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL reset_release_idle got=%03h exp=%03h", observed(), e);
    end
  endtask

  task automatic test_alu_fwd();
    logic [11:0] e;
    @(negedge clk);
    idle();
    rf_wr_mem = 1; rd_mem = 5; rs1_de = 5; rs1_used = 1; rs2_de = 3; rs2_used = 1;
    #1;
    e = pack(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL alu_fwd_rs1 got=%03h exp=%03h", observed(), e);
    end
    rs2_de = 5;
    #1;
    e = pack(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL alu_fwd_both got=%03h exp=%03h", observed(), e);
    end
    rd_mem = 0; rs1_de = 0; rs2_de = 0;
    #1;
    e = pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL alu_fwd_x0 got=%03h exp=%03h", observed(), e);
    end
    rd_mem = 9; rs1_de = 9; rs1_used = 0;
    #1;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL alu_fwd_unused got=%03h exp=%03h", observed(), e);
    end
  endtask

  task automatic test_load_use();
    logic [11:0] e;
    @(negedge clk);
    idle();
    mem_is_load = 1; dmem_req = 1; dmem_ack = 1; rf_wr_mem = 1; rd_mem = 7;
    rs2_de = 7; rs2_used = 1; rs1_de = 2; rs1_used = 1;
    #1;
    e = pack(1, 1, 0, 0, 1, 1, 2'd0, 2'd0, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL load_use_cycle0 got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    dmem_req = 0; dmem_ack = 0; mem_is_load = 0; rf_wr_mem = 0; rd_mem = 0;
    #1;
    e = pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 0, 1);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL load_use_cycle1 got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    idle();
    #1;
    e = '0;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL load_use_cycle2 got=%03h exp=%03h", observed(), e);
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] e;
    int held = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      dmem_req = 1;
      #1;
      held += stall_mem;
      e = pack(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, k != 0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL mem_wait_cycle%0d got=%03h exp=%03h", k, observed(), e);
      end
    end
    @(negedge clk);
    dmem_ack = 1;
    #1;
    held += stall_mem;
    e = pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL mem_wait_ack got=%03h exp=%03h", observed(), e);
    end
    n_checks++;
    if (held !== 3) begin
      n_fail++; $display("FAIL mem_wait_stall_len got=%0d exp=3", held);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_back_to_run busy got=%0b exp=0", busy);
    end
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (perf_stall_cyc !== 32'd4) begin
      n_fail++; $display("FAIL perf_stall_cyc got=%0d exp=4", perf_stall_cyc);
    end
    n_checks++;
    if (perf_flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_flush_cnt got=%0d exp=0", perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    logic [11:0] e;
    @(negedge clk);
    idle();
    dmem_req = 1;
    for (int k = 0; k <= TMO; k++) begin
      #1;
      e = pack(1, 1, 1, 0, k == TMO, 0, 2'd0, 2'd0, k == TMO, k != 0);
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL timeout_cycle%0d got=%03h exp=%03h", k, observed(), e);
      end
      @(negedge clk);
    end
    idle();
    #1;
    e = '0;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL timeout_back_to_run got=%03h exp=%03h", observed(), e);
    end
  endtask

  task automatic test_trap_priority();
    logic [11:0] e;
    @(negedge clk);
    idle();
    trap = 1; br_taken = 1; dmem_req = 1; mem_is_load = 1;
    #1;
    e = pack(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL trap_priority got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL trap_stays_run busy got=%0b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [11:0] e;
    @(negedge clk);
    idle();
    dmem_req = 1;
    @(negedge clk);
    #1;
    e = pack(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 1);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL mid_wait_entered got=%03h exp=%03h", observed(), e);
    end
    #1 rst_n = 0;
    #1;
    e = '0;
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL mid_wait_async_reset got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    e = pack(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0);
    n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL mid_wait_restart_run got=%03h exp=%03h", observed(), e);
    end
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [11:0] e;
    int ack_div;
    mw_cnt = 0; lu_pend = 0; lu_h1 = 0; lu_h2 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ack_div     = ((i / 250) % 2) ? 8 : 2;
      trap        = ($urandom_range(0, 15) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      dmem_req    = $urandom_range(0, 1);
      dmem_ack    = ($urandom_range(0, ack_div - 1) == 0);
      mem_is_load = $urandom_range(0, 1);
      rf_wr_mem   = ($urandom_range(0, 3) != 0);
      rd_mem      = 5'($urandom_range(0, 3));
      rs1_de      = 5'($urandom_range(0, 3));
      rs2_de      = 5'($urandom_range(0, 3));
      rs1_used    = $urandom_range(0, 1);
      rs2_used    = $urandom_range(0, 1);
      #1;
      e = model_expect();
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL random_cycle%0d got=%03h exp=%03h", i, observed(), e);
      end
      model_advance();
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_mem_wait();
    test_perf();
    test_timeout();
    test_trap_priority();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
